// File: rtl/mem_io_if.sv
// rtl/mem_io_if.sv - core-side data memory bus between the CPU core and mem_io.
interface mem_io_if;
   logic        memread;
   logic        memwrite;
   logic [31:0] mem_addr;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   modport master (output memread, memwrite, mem_addr, mem_writedata, input mem_readdata);
   modport slave  (input memread, memwrite, mem_addr, mem_writedata, output mem_readdata);
endinterface

// File: rtl/mem_io.sv
// rtl/mem_io.sv - data RAM plus memory-mapped UART transmitter behind the core's data port.
module mem_io #(
   parameter int DATA_WORDS   = 1024,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic     clk,
   input  logic     reset,
   mem_io_if.slave  bus,
   output logic     uart_tx,
   output logic     mem_fault
);
   localparam int AW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(DATA_WORDS * 4);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [31:0] ram [DATA_WORDS];
   logic [7:0]  fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   state_t        state, nstate;
   logic [BW-1:0] cnt, ncnt;
   logic [2:0]    bit_idx, nbit;
   logic [7:0]    shift, nshift;
   logic          pop, tx_d, tx_busy;

   logic is_ram, is_udata, is_ustat, unmapped;
   logic fifo_full, fifo_empty, count_hi, push_req, push_ok, last;
   logic [AW-1:0] idx;

   assign is_ram     = bus.mem_addr < RAM_BYTES;
   assign is_udata   = bus.mem_addr[31:2] == 30'h3FFF_C000;
   assign is_ustat   = bus.mem_addr[31:2] == 30'h3FFF_C001;
   assign unmapped   = !(is_ram || is_udata || is_ustat);
   assign idx        = bus.mem_addr[AW+1:2];

   assign fifo_full  = count == CW'(FIFO_DEPTH);
   assign fifo_empty = count == '0;
   assign count_hi   = count >= CW'(FIFO_DEPTH / 2);
   assign push_req   = bus.memwrite && is_udata;
   // A full FIFO still accepts a push when the serialiser pops in the same cycle.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign last       = cnt == BW'(CLKS_PER_BIT - 1);

   always_comb begin
      bus.mem_readdata = 32'b0;
      if (bus.memread) begin
         if (is_ram)
            bus.mem_readdata = ram[idx];
         else if (is_ustat)
            bus.mem_readdata = {26'b0, overflow, count_hi, 1'b0, tx_busy, fifo_empty, fifo_full};
      end
   end

   always_ff @(posedge clk) begin
      if (bus.memwrite && is_ram)
         ram[idx] <= bus.mem_writedata;
      if (push_ok)
         fifo[wr_ptr] <= bus.mem_writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
         else if (bus.memwrite && is_ustat && bus.mem_writedata[5])
            overflow <= 1'b0;
         if ((bus.memread || bus.memwrite) && unmapped)
            mem_fault <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
      end else begin
         state   <= nstate;
         cnt     <= ncnt;
         bit_idx <= nbit;
         shift   <= nshift;
         uart_tx <= tx_d;
      end
   end

   always_comb begin
      nstate = state;
      ncnt   = cnt + 1'b1;
      nbit   = bit_idx;
      nshift = shift;
      pop    = 1'b0;
      case (state)
         IDLE: begin
            ncnt = '0;
            if (!fifo_empty) begin
               pop    = 1'b1;
               nshift = fifo[rd_ptr];
               nstate = START;
            end
         end
         START: if (last) begin
            ncnt   = '0;
            nbit   = '0;
            nstate = DATA;
         end
         DATA: if (last) begin
            ncnt   = '0;
            nshift = shift >> 1;
            if (bit_idx == 3'd7)
               nstate = STOP;
            else
               nbit = bit_idx + 1'b1;
         end
         STOP: if (last) begin
            ncnt = '0;
            // Chain straight into the next frame when more data is queued.
            if (!fifo_empty) begin
               pop    = 1'b1;
               nshift = fifo[rd_ptr];
               nstate = START;
            end else begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // uart_tx is registered, so it is derived from the post-edge state.
   always_comb begin
      tx_busy = state != IDLE;
      case (nstate)
         START:   tx_d = 1'b0;
         DATA:    tx_d = nshift[0];
         default: tx_d = 1'b1;
      endcase
   end
endmodule

// File: doc/mem_io.md
Name: mem_io

Overview:
- Data-side memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's memread/memwrite/mem_addr/mem_writedata and returns mem_readdata combinationally, so loads still complete in one cycle.
- Contains a word-organised data RAM and a memory-mapped UART transmitter (TX FIFO plus serialiser FSM) for program output.

Parameters:
DATA_WORDS, 1024, number of 32-bit RAM words.
FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >=2).
CLKS_PER_BIT, 868, clk cycles per UART bit (>=2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
memread  input  1  load strobe from core.
memwrite  input  1  store strobe from core.
mem_addr  input  32  byte address; bits [1:0] ignored.
mem_writedata  input  32  store data.
mem_readdata  output  32  load data, combinational.
uart_tx  output  1  serial TX line, idle high.
mem_fault  output  1  sticky flag: access to an unmapped address.

Behaviour:
- Address map:
  - RAM: addr < DATA_WORDS*4, word index addr[..:2].
  - UART_DATA: 0xFFFF_0000. Write pushes mem_writedata[7:0]. Read returns 0.
  - UART_STATUS: 0xFFFF_0004. Read returns {26'b0, overflow[5], count_hi[4], tx_busy[2], fifo_empty[1], fifo_full[0]}, where count_hi means count >= FIFO_DEPTH/2.
  - Writing UART_STATUS with bit5=1 clears overflow. All other bits are ignored.
  - Every other address is unmapped.
- Reads:
  - mem_readdata is a pure function of the current state and mem_addr when memread=1. It is 32'b0 when memread=0.
  - Reads have no side effects.
- Writes: take effect at the rising edge while memwrite=1.
- memread and memwrite both high: the write is performed, and mem_readdata shows the pre-edge value.
- Unmapped access (read or write): reads return 0, writes are dropped, and mem_fault sets at the next edge. mem_fault clears only on reset.
- Reset (reset=0, asynchronous):
  - uart_tx=1, FIFO empty, overflow=0, mem_fault=0, FSM=IDLE, all counters 0.
  - RAM contents are not cleared; reading a RAM word before its first write returns undefined data.
  - Reset asserted mid-frame aborts the frame immediately, with uart_tx=1 asynchronously.
- FIFO:
  - Circular buffer with read/write pointers and a count register.
  - Push when full: the byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle: both succeed and count is unchanged, including when full.
  - Pop only happens when pre-edge count > 0.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO is non-empty, pop into shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
  - tx_busy = (state != IDLE).
  - uart_tx is registered.
- Latency: a store to UART_DATA at edge N with FIFO empty and FSM IDLE gives a pop at edge N+1, and uart_tx falls after edge N+1. One frame is exactly 10*CLKS_PER_BIT cycles.
- Bit counter counts 0..CLKS_PER_BIT-1 and resets on every state/bit change.

Test Plan:
- RAM write/read: store 0xDEADBEEF to 0x10, then load 0x10 → mem_readdata=0xDEADBEEF the same cycle. Load 0x14 with memread=0 → 0.
- Single UART byte (CLKS_PER_BIT=4): store 0x000000A5 to 0xFFFF_0000 → uart_tx low from the cycle after the next edge. Sample each 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_busy=1 throughout, then STATUS reads 0x2.
- Back-to-back: push 0x41, 0x42 in consecutive cycles → two frames with no idle gap, 80 cycles total at CLKS_PER_BIT=4.
- Overflow: with the FSM stalled mid-frame, push FIFO_DEPTH+2 bytes → STATUS bit0=1, bit5=1, and only FIFO_DEPTH+1 bytes are transmitted (one already in the shifter). Write 0x20 to STATUS → bit5=0.
- Unmapped: store to 0x8000_0000 → mem_fault=1 after the edge, RAM unchanged, uart_tx idle. A load from the same address returns 0.
- Async reset mid-frame: drop reset during DATA bit 3 → uart_tx=1 and STATUS=0x2 immediately, with no clock edge. After release, a new push transmits normally.
